// File: rtl/pulse_train_monitor.sv
// pulse_train_monitor: samples a generator's serial stream, detects and locks
// onto a programmed 16-bit pattern repeating every 16 samples, and keeps
// pulse-width and rising-edge statistics.
module pulse_train_monitor #(
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned MISS_LIMIT = 2
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        E,
   input  logic        serial_in,
   input  logic [15:0] pattern,
   input  logic        clr_stats,
   output logic        match,
   output logic        locked,
   output logic        lock_lost,
   output logic [4:0]  high_len,
   output logic        width_valid,
   output logic [7:0]  rise_count
);

   localparam int unsigned WIN_W   = 16;
   localparam int unsigned FILL_W  = 5;
   localparam int unsigned PH_W    = 4;
   localparam int unsigned RUN_W   = 5;
   localparam int unsigned RISE_W  = 8;
   localparam int unsigned CNT_MAX = (LOCK_COUNT > MISS_LIMIT) ? LOCK_COUNT : MISS_LIMIT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIN_W-1:0]   w_q, w_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               prev_q, prev_d;
   logic               match_d;
   logic               lock_lost_d;
   logic [RUN_W-1:0]   high_len_d;
   logic               width_valid_d;
   logic [RISE_W-1:0]  rise_d;
   logic               wrap;

   // Next-state: window, lock FSM with phase tracking, run length and rise count
   always_comb begin
      w_d           = w_q;
      fill_d        = fill_q;
      state_d       = state_q;
      phase_d       = phase_q;
      cnt_d         = cnt_q;
      run_d         = run_q;
      prev_d        = prev_q;
      match_d       = 1'b0;
      lock_lost_d   = 1'b0;
      high_len_d    = high_len;
      width_valid_d = 1'b0;
      rise_d        = rise_count;
      wrap          = 1'b0;

      if (E) begin
         w_d = {w_q[WIN_W-2:0], serial_in};
         if (fill_q != FILL_W'(WIN_W)) begin
            fill_d = fill_q + FILL_W'(1);
         end
         match_d = (fill_d == FILL_W'(WIN_W)) && (w_d == pattern);
         wrap    = (phase_q == {PH_W{1'b1}});

         case (state_q)
            ST_SEARCH: begin
               if (match_d) begin
                  state_d = ST_CHECK;
                  phase_d = '0;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_CHECK: begin
               phase_d = phase_q + PH_W'(1);
               if (wrap) begin
                  if (match_d) begin
                     cnt_d = cnt_q + CNT_W'(1);
                     if (cnt_d == CNT_W'(LOCK_COUNT)) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                     end
                  end else begin
                     state_d = ST_SEARCH;
                  end
               end
            end
            ST_LOCKED: begin
               phase_d = phase_q + PH_W'(1);
               if (wrap) begin
                  if (match_d) begin
                     cnt_d = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                     if (cnt_d == CNT_W'(MISS_LIMIT)) begin
                        state_d     = ST_SEARCH;
                        lock_lost_d = 1'b1;
                     end
                  end
               end
            end
            default: state_d = ST_SEARCH;
         endcase

         // High-run length, reported on the falling sample
         if (serial_in) begin
            if (!prev_q) begin
               run_d = RUN_W'(1);
            end else if (run_q != {RUN_W{1'b1}}) begin
               run_d = run_q + RUN_W'(1);
            end
         end else if (prev_q) begin
            high_len_d    = run_q;
            width_valid_d = 1'b1;
         end

         if (serial_in && !prev_q && (rise_count != {RISE_W{1'b1}})) begin
            rise_d = rise_count + RISE_W'(1);
         end
         prev_d = serial_in;
      end

      // Statistics clear wins over a simultaneous rise and ignores E
      if (clr_stats) begin
         rise_d = '0;
      end
   end

   // Lock FSM state register
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         w_q         <= '0;
         fill_q      <= '0;
         phase_q     <= '0;
         cnt_q       <= '0;
         run_q       <= '0;
         prev_q      <= 1'b0;
         match       <= 1'b0;
         locked      <= 1'b0;
         lock_lost   <= 1'b0;
         high_len    <= '0;
         width_valid <= 1'b0;
         rise_count  <= '0;
      end else begin
         w_q         <= w_d;
         fill_q      <= fill_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         run_q       <= run_d;
         prev_q      <= prev_d;
         match       <= match_d;
         locked      <= (state_d == ST_LOCKED);
         lock_lost   <= lock_lost_d;
         high_len    <= high_len_d;
         width_valid <= width_valid_d;
         rise_count  <= rise_d;
      end
   end

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Bench for pulse_train_monitor: behavioural reference model feeding a
// scoreboard queue, plus directed checks at the key sample edges.
module tb_pulse_train_monitor;

   localparam int unsigned LOCK_COUNT = 3;
   localparam int unsigned MISS_LIMIT = 2;

   logic        CLK;
   logic        CLR;
   logic        E;
   logic        serial_in;
   logic [15:0] pattern;
   logic        clr_stats;
   logic        match;
   logic        locked;
   logic        lock_lost;
   logic [4:0]  high_len;
   logic        width_valid;
   logic [7:0]  rise_count;

   pulse_train_monitor #(
      .LOCK_COUNT (LOCK_COUNT),
      .MISS_LIMIT (MISS_LIMIT)
   ) dut (
      .CLK         (CLK),
      .CLR         (CLR),
      .E           (E),
      .serial_in   (serial_in),
      .pattern     (pattern),
      .clr_stats   (clr_stats),
      .match       (match),
      .locked      (locked),
      .lock_lost   (lock_lost),
      .high_len    (high_len),
      .width_valid (width_valid),
      .rise_count  (rise_count)
   );

   typedef struct {
      logic       m;
      logic       lk;
      logic       ll;
      logic [4:0] hl;
      logic       wv;
      logic [7:0] rc;
   } exp_t;

   exp_t sb_q[$];

   int n_vec  = 0;
   int n_fail = 0;
   int n      = 0;

   // Reference model state
   logic [15:0] m_w;
   int          m_fill, m_state, m_phase, m_good, m_miss, m_run, m_hl, m_rc;
   logic        m_prev, m_match, m_wv, m_ll;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (sample %0d, t=%0t)", tag, obs, exp, n, $time);
      end
   endtask

   task automatic model_reset();
      m_w = '0; m_fill = 0; m_state = 0; m_phase = 0; m_good = 0; m_miss = 0;
      m_run = 0; m_hl = 0; m_rc = 0; m_prev = 1'b0;
      m_match = 1'b0; m_wv = 1'b0; m_ll = 1'b0;
   endtask

   task automatic model_step(input logic sin, input logic en, input logic cs);
      logic wrap;
      m_match = 1'b0; m_wv = 1'b0; m_ll = 1'b0;
      if (en) begin
         m_w = {m_w[14:0], sin};
         if (m_fill < 16) m_fill++;
         m_match = (m_fill == 16) && (m_w == pattern);
         wrap = (m_phase == 15);
         if (m_state == 0) begin
            if (m_match) begin m_state = 1; m_phase = 0; m_good = 1; end
         end else begin
            m_phase = (m_phase + 1) % 16;
            if (wrap && m_state == 1) begin
               if (!m_match) m_state = 0;
               else begin
                  m_good++;
                  if (m_good == LOCK_COUNT) begin m_state = 2; m_miss = 0; end
               end
            end else if (wrap) begin
               if (m_match) m_miss = 0;
               else begin
                  m_miss++;
                  if (m_miss == MISS_LIMIT) begin m_state = 0; m_ll = 1'b1; end
               end
            end
         end
         if (sin && !m_prev && m_rc < 255) m_rc++;
         if (sin) m_run = m_prev ? ((m_run < 31) ? m_run + 1 : 31) : 1;
         else if (m_prev) begin m_hl = m_run; m_wv = 1'b1; end
         m_prev = sin;
      end
      if (cs) m_rc = 0;
   endtask

   // Drive one cycle, queue the model's expectation, compare after the edge
   task automatic step(input logic sin, input logic en, input logic cs);
      exp_t e, g;
      @(negedge CLK);
      serial_in = sin; E = en; clr_stats = cs;
      model_step(sin, en, cs);
      e.m = m_match; e.lk = (m_state == 2); e.ll = m_ll;
      e.hl = 5'(m_hl); e.wv = m_wv; e.rc = 8'(m_rc);
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      if (en) n++;
      if (sb_q.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         g = sb_q.pop_front();
         check("match", match, g.m);
         check("locked", locked, g.lk);
         check("lock_lost", lock_lost, g.ll);
         check("high_len", high_len, g.hl);
         check("width_valid", width_valid, g.wv);
         check("rise_count", rise_count, g.rc);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      CLR = 1'b0; E = 1'b0; serial_in = 1'b0; clr_stats = 1'b0;
      model_reset();
      n = 0;
      @(negedge CLK);
      @(negedge CLK);
      CLR = 1'b1;
   endtask

   function automatic logic bit_of(input logic [15:0] word, input int idx);
      return word[15 - (idx % 16)];
   endfunction

   initial begin
      int hl_save, rc_save;
      CLR = 1'b0; E = 1'b0; serial_in = 1'b0; clr_stats = 1'b0; pattern = 16'hF00F;
      model_reset();
      #12;
      check("rst_match", match, 0);
      check("rst_locked", locked, 0);
      check("rst_high_len", high_len, 0);
      check("rst_rise", rise_count, 0);

      // Lock, width, rise count, clr_stats and an enable gap on 0xF00F
      do_reset();
      pattern = 16'hF00F;
      for (int i = 0; i < 80; i++) begin
         if (i == 56) begin
            hl_save = high_len; rc_save = rise_count;
            for (int g = 0; g < 10; g++) begin
               step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
               check("gap_match", match, 0);
               check("gap_wv", width_valid, 0);
               check("gap_locked", locked, 1);
               check("gap_hl", high_len, hl_save);
               check("gap_rc", rise_count, rc_save);
            end
         end
         step(bit_of(16'hF00F, i), 1'b1, i == 44);
         check("no_lock_lost", lock_lost, 0);
         if (n == 15) check("no_match_15", match, 0);
         if (n == 16 || n == 32 || n == 48 || n == 64 || n == 80) check("match_wrap", match, 1);
         if (n == 47) check("unlocked_47", locked, 0);
         if (n >= 48) check("locked", locked, 1);
         if (n == 5)  begin check("wv_5", width_valid, 1); check("hl_5", high_len, 4); end
         if (n == 21) begin check("wv_21", width_valid, 1); check("hl_21", high_len, 8); end
         if (n == 32) check("rise_32", rise_count, 3);
         if (n == 45) check("clr_stats", rise_count, 0);
      end

      // Lock loss: zeros from sample 49
      do_reset();
      for (int i = 0; i < 81; i++) begin
         step((i < 48) ? bit_of(16'hF00F, i) : 1'b0, 1'b1, 1'b0);
         if (n == 64) check("locked_after_1miss", locked, 1);
         if (n >= 49) check("hl_hold", high_len, 4);
         if (n == 80) begin check("lock_lost", lock_lost, 1); check("unlocked", locked, 0); end
         if (n == 81) check("lock_lost_1cyc", lock_lost, 0);
      end

      // Symmetric pattern 0xAAAA, then async reset while locked at rise_count=200
      do_reset();
      pattern = 16'hAAAA;
      for (int i = 0; i < 400; i++) begin
         step(bit_of(16'hAAAA, i), 1'b1, 1'b0);
         if (n >= 16 && n <= 50) check("sym_match", match, (n % 2) == 0);
         if (n == 47) check("sym_unlocked_47", locked, 0);
         if (n == 48) check("sym_locked_48", locked, 1);
      end
      check("rise_200", rise_count, 200);
      check("locked_pre_rst", locked, 1);
      #2;
      CLR = 1'b0;
      #1;
      model_reset();
      check("arst_match", match, 0);
      check("arst_locked", locked, 0);
      check("arst_lock_lost", lock_lost, 0);
      check("arst_high_len", high_len, 0);
      check("arst_wv", width_valid, 0);
      check("arst_rise", rise_count, 0);
      @(negedge CLK);
      CLR = 1'b1;

      // Rise-count saturation: 300 rises
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(bit_of(16'hAAAA, i), 1'b1, 1'b0);
      end
      check("rise_sat", rise_count, 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
